// File: rtl/rtc_calendar_core.sv
// Real-time-clock core: 1 Hz prescaler, Gregorian calendar with validated presets,
// 12/24h output formatting and NUM_ALARMS time-of-day alarms with sticky flags.
module rtc_calendar_core #(
    parameter int CLK_FREQ_HZ = 32768,
    parameter int YEAR_W      = 12,
    parameter int RESET_YEAR  = 2000,
    parameter int NUM_ALARMS  = 2,
    localparam int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en_i,
    input  logic                  mode_i,
    input  logic                  preset_valid_i,
    input  logic [5:0]            init_sec_i,
    input  logic [5:0]            init_min_i,
    input  logic [4:0]            init_hour_i,
    input  logic [2:0]            init_day_of_week_i,
    input  logic [4:0]            init_day_of_month_i,
    input  logic [3:0]            init_month_i,
    input  logic [YEAR_W-1:0]     init_year_i,
    input  logic                  alarm_wr_i,
    input  logic [AW-1:0]         alarm_idx_i,
    input  logic                  alarm_en_i,
    input  logic [5:0]            alarm_sec_i,
    input  logic [5:0]            alarm_min_i,
    input  logic [4:0]            alarm_hour_i,
    input  logic [NUM_ALARMS-1:0] alarm_clr_i,
    output logic                  tick_o,
    output logic                  preset_err_o,
    output logic [5:0]            cur_sec_o,
    output logic [5:0]            cur_min_o,
    output logic [4:0]            cur_hour_o,
    output logic                  cur_pm_o,
    output logic [2:0]            cur_day_of_week_o,
    output logic [4:0]            cur_day_of_month_o,
    output logic [3:0]            cur_month_o,
    output logic [YEAR_W-1:0]     cur_year_o,
    output logic [NUM_ALARMS-1:0] alarm_irq_o
);

    localparam int PW = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ_HZ - 1);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        logic [31:0] yv;
        yv = 32'(y);
        return (yv % 32'd4 == 32'd0) && ((yv % 32'd100 != 32'd0) || (yv % 32'd400 == 32'd0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    logic [PW-1:0]     presc_q;
    logic [5:0]        sec_q, min_q;
    logic [4:0]        hour_q;
    logic [2:0]        dow_q;
    logic [4:0]        dom_q;
    logic [3:0]        month_q;
    logic [YEAR_W-1:0] year_q;
    logic              upd_q;
    logic              preset_ok;

    logic [NUM_ALARMS-1:0]       al_en_q;
    logic [NUM_ALARMS-1:0][5:0]  al_sec_q, al_min_q;
    logic [NUM_ALARMS-1:0][4:0]  al_hour_q;
    logic [NUM_ALARMS-1:0]       match;

    assign preset_ok = preset_valid_i
                    && (init_sec_i < 6'd60) && (init_min_i < 6'd60) && (init_hour_i < 5'd24)
                    && (init_day_of_week_i != 3'd0)
                    && (init_month_i >= 4'd1) && (init_month_i <= 4'd12)
                    && (init_day_of_month_i != 5'd0)
                    && (init_day_of_month_i <= days_in_month(init_month_i, init_year_i));

    // A valid preset clears the prescaler, so it also suppresses a coincident tick.
    assign tick_o = en_i && (presc_q == TC) && !preset_ok;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q      <= '0;
            sec_q        <= '0;
            min_q        <= '0;
            hour_q       <= '0;
            dow_q        <= 3'd1;
            dom_q        <= 5'd1;
            month_q      <= 4'd1;
            year_q       <= YEAR_W'(RESET_YEAR);
            upd_q        <= 1'b0;
            preset_err_o <= 1'b0;
        end else begin
            upd_q        <= tick_o || preset_ok;
            preset_err_o <= preset_valid_i && !preset_ok;
            if (preset_ok) begin
                presc_q <= '0;
                sec_q   <= init_sec_i;
                min_q   <= init_min_i;
                hour_q  <= init_hour_i;
                dow_q   <= init_day_of_week_i;
                dom_q   <= init_day_of_month_i;
                month_q <= init_month_i;
                year_q  <= init_year_i;
            end else if (tick_o) begin
                presc_q <= '0;
                if (sec_q != 6'd59) begin
                    sec_q <= sec_q + 6'd1;
                end else begin
                    sec_q <= '0;
                    if (min_q != 6'd59) begin
                        min_q <= min_q + 6'd1;
                    end else begin
                        min_q <= '0;
                        if (hour_q != 5'd23) begin
                            hour_q <= hour_q + 5'd1;
                        end else begin
                            hour_q <= '0;
                            dow_q  <= (dow_q == 3'd7) ? 3'd1 : dow_q + 3'd1;
                            if (dom_q != days_in_month(month_q, year_q)) begin
                                dom_q <= dom_q + 5'd1;
                            end else begin
                                dom_q <= 5'd1;
                                if (month_q != 4'd12) begin
                                    month_q <= month_q + 4'd1;
                                end else begin
                                    month_q <= 4'd1;
                                    year_q  <= year_q + 1'b1;
                                end
                            end
                        end
                    end
                end
            end else if (en_i) begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    // Alarms compare against the registered time only in the cycle after it changed.
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            match[i] = upd_q && al_en_q[i] && (al_sec_q[i] == sec_q)
                    && (al_min_q[i] == min_q) && (al_hour_q[i] == hour_q);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            al_en_q     <= '0;
            al_sec_q    <= '0;
            al_min_q    <= '0;
            al_hour_q   <= '0;
            alarm_irq_o <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_wr_i && (alarm_idx_i == AW'(i))) begin
                    al_en_q[i]   <= alarm_en_i;
                    al_sec_q[i]  <= alarm_sec_i;
                    al_min_q[i]  <= alarm_min_i;
                    al_hour_q[i] <= alarm_hour_i;
                end
            end
            alarm_irq_o <= match | (alarm_irq_o & ~alarm_clr_i);
        end
    end

    always_comb begin
        cur_hour_o = hour_q;
        cur_pm_o   = 1'b0;
        if (mode_i) begin
            if (hour_q == 5'd0) begin
                cur_hour_o = 5'd12;
            end else if (hour_q > 5'd12) begin
                cur_hour_o = hour_q - 5'd12;
                cur_pm_o   = 1'b1;
            end else if (hour_q == 5'd12) begin
                cur_pm_o   = 1'b1;
            end
        end
    end

    assign cur_sec_o          = sec_q;
    assign cur_min_o          = min_q;
    assign cur_day_of_week_o  = dow_q;
    assign cur_day_of_month_o = dom_q;
    assign cur_month_o        = month_q;
    assign cur_year_o         = year_q;

endmodule

// File: doc/rtc_calendar_core.md
# rtc_calendar_core

Parametrised real-time-clock core: divides the system clock to a 1 Hz tick internally and keeps a full calendar. Calendar fields are seconds, minutes, hours, day-of-week, day-of-month, month and a parametrised-width absolute year with Gregorian leap-year rules. Hours are kept internally in 24-hour form and output in 24-hour or 12-hour format. The core validates presets and provides NUM_ALARMS independent time-of-day alarms with sticky interrupts. It succeeds the 1 Hz-clocked time counter and sits between the bus register file and the display/interrupt logic.

## Interface
- CLK_FREQ_HZ, 32768: input clock frequency; prescaler terminal count is CLK_FREQ_HZ-1 (must be ≥2)
- YEAR_W, 12: year field width
- RESET_YEAR, 2000: year value after reset
- NUM_ALARMS, 2: number of alarm channels (≥1); AW = max(1, $clog2(NUM_ALARMS))
- clk_i  in  1  system clock
- rstn_i  in  1  reset, asynchronous, active-low
- en_i  in  1  prescaler/count enable; 0 freezes prescaler and calendar
- mode_i  in  1  output hour format: 0 = 24h, 1 = 12h
- preset_valid_i  in  1  single-cycle load strobe for the init_* fields
- init_sec_i / init_min_i  in  6 each  preset seconds / minutes
- init_hour_i  in  5  preset hour, always 24h format, 0..23
- init_day_of_week_i  in  3  1..7 (1 = Sunday)
- init_day_of_month_i  in  5  1..31
- init_month_i  in  4  1..12
- init_year_i  in  YEAR_W  absolute year
- alarm_wr_i  in  1  write strobe for alarm channel alarm_idx_i
- alarm_idx_i  in  AW  alarm channel select
- alarm_en_i  in  1  enable bit written with the alarm
- alarm_sec_i / alarm_min_i  in  6 each  alarm seconds / minutes
- alarm_hour_i  in  5  alarm hour, 24h format
- alarm_clr_i  in  NUM_ALARMS  per-channel interrupt clear
- tick_o  out  1  one-cycle 1 Hz strobe
- preset_err_o  out  1  one-cycle pulse: preset rejected
- cur_sec_o / cur_min_o  out  6 each  current seconds / minutes
- cur_hour_o  out  5  hour in the format selected by mode_i
- cur_pm_o  out  1  12h mode: 1 when internal hour ≥ 12; 24h mode: 0
- cur_day_of_week_o  out  3  current day of week
- cur_day_of_month_o  out  5  current day of month
- cur_month_o  out  4  current month
- cur_year_o  out  YEAR_W  current year
- alarm_irq_o  out  NUM_ALARMS  sticky per-channel alarm flags

## Operation
- Reset values:
  - Prescaler 0; time 00:00:00; day_of_week 1; day_of_month 1; month 1; year RESET_YEAR.
  - Alarms disabled, fields 0; alarm_irq_o 0; tick_o 0; preset_err_o 0.
  - cur_hour_o reads 12 in 12h mode.
- Prescaler:
  - Counts while en_i = 1.
  - At CLK_FREQ_HZ-1: tick_o = 1 that cycle, prescaler wraps to 0 and the calendar advances by one second on the same edge.
- Carry chain (each step only when the previous field wraps):
  - sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0 carries to day.
  - A day carry advances day_of_week (7→1) and day_of_month.
  - day_of_month wraps from days_in_month to 1 and carries to month; month 12→1 carries to year.
  - Year wraps from 2^YEAR_W-1 to 0.
- days_in_month:
  - 31 for months 1/3/5/7/8/10/12; 30 for 4/6/9/11.
  - February is 29 if leap, else 28.
  - Leap year: year%4 == 0 and (year%100 != 0 or year%400 == 0).
- Preset validity: sec<60, min<60, hour<24, dow 1..7, month 1..12, 1 ≤ dom ≤ days_in_month(init_month_i, init_year_i).
  - Valid: all fields load on the next edge, prescaler is cleared to 0, and no second advance happens that cycle (preset beats tick; tick_o is still 0 that cycle).
  - Invalid: calendar and prescaler are untouched; preset_err_o pulses for one cycle.
- 12h output mapping (combinational from the internal hour and mode_i):
  - 0 → 12 AM; 1..11 → same value AM; 12 → 12 PM; 13..23 → hour-12 PM.
  - The mode_i change takes effect on the same cycle and never alters stored time.
- Alarms:
  - alarm_wr_i stores en/sec/min/hour into channel alarm_idx_i; idx ≥ NUM_ALARMS is ignored.
  - Out-of-range alarm fields are stored but never match.
  - Match: channel enabled and stored sec/min/hour equal the registered internal time, evaluated only in the cycle after a time update (tick advance or valid preset).
  - A match sets the channel's irq.
  - alarm_clr_i clears the corresponding irq; set beats clear in the same cycle.
  - A write to a channel does not modify its irq.

## Timing
- cur_* change on the edge ending the tick_o cycle and are visible the next cycle.
- Preset data is visible one cycle after preset_valid_i.
- alarm_irq_o rises two cycles after the tick_o / preset_valid_i cycle, i.e. one cycle after the new time is visible.
- preset_err_o is registered: high in the cycle after the strobe.
- rstn_i low mid-operation immediately forces all reset values, independent of the clock.
- en_i = 0 holds the prescaler value.
- A preset while en_i = 0 loads normally.

## Test plan
- Year rollover: CLK_FREQ_HZ = 4; preset 2021-12-31 23:59:50, dow 5 → after 10 ticks reads 2022-01-01 00:00:00, dow 6; tick_o period is 4 cycles.
- Leap rules: preset 23:59:59 on Feb-28 of 2024, 2100 and 2000 → one tick later reads 02-29, 03-01 and 02-29 respectively; 2024-02-29 23:59:59 → 03-01.
- 12h mode:
  - hour 0 → cur_hour_o = 12, pm 0.
  - hour 13 → 1, pm 1; hour 12 → 12, pm 1.
  - Toggling mode_i mid-count leaves sec/min untouched.
- Invalid preset: 2023-02-29, sec 60 or month 0 → preset_err_o pulses once; all cur_* unchanged.
- Alarm channel 1:
  - Set to 00:00:05 enabled; preset 00:00:03 → irq[1] rises two cycles after the 2nd tick; irq[0] stays 0.
  - clr[1] asserted in the set cycle → irq stays 1; clr[1] later → 0.
- Reset/enable:
  - rstn_i low mid-count → all outputs at reset values at once.
  - en_i = 0 for 20 cycles → no tick_o and calendar frozen; counting resumes from the held prescaler value.
